// File: rtl/fpnew_lane_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fpnew_lane_sequencer
// Brief    : Runs a vectorial FP op lane by lane over NumUnits physical units,
//            then returns one assembled result. Option: FPNEW_LANE_SEQ_STALL_CNT_EN
// Revision : 1.0 - initial release
// ============================================================================
module fpnew_lane_sequencer #(
    parameter int unsigned Width         = 64,
    parameter int unsigned FpWidth       = 16,
    parameter int unsigned NumUnits      = 2,
    parameter int unsigned NumOperands   = 3,
    parameter int unsigned TagWidth      = 8,
    parameter bit          EnableVectors = 1'b1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NumOperands*Width-1:0]           operands_i,
    input  logic [NumOperands-1:0]                 is_boxed_i,
    input  logic                                   vectorial_op_i,
    input  logic [TagWidth-1:0]                    tag_i,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    input  logic                                   flush_i,
    output logic [Width-1:0]                       result_o,
    output logic [4:0]                             status_o,
    output logic                                   extension_bit_o,
    output logic [TagWidth-1:0]                    tag_o,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic                                   busy_o,
    output logic [NumUnits*NumOperands*FpWidth-1:0] unit_operands_o,
    output logic [NumUnits*NumOperands-1:0]        unit_is_boxed_o,
    output logic [NumUnits-1:0]                    unit_valid_o,
    input  logic [NumUnits-1:0]                    unit_ready_i,
    input  logic [NumUnits*FpWidth-1:0]            unit_result_i,
    input  logic [NumUnits*5-1:0]                  unit_status_i,
    input  logic [NumUnits-1:0]                    unit_ext_bit_i,
    input  logic [NumUnits-1:0]                    unit_out_valid_i,
    output logic [NumUnits-1:0]                    unit_out_ready_o,
    output logic                                   unit_flush_o,
    output logic [31:0]                            stall_cnt_o
);
    localparam int unsigned NUM_LANES = Width / FpWidth;
    localparam int unsigned BEATS     = (NUM_LANES + NumUnits - 1) / NumUnits;
    localparam int unsigned BW        = $clog2(BEATS + 1);
    localparam int unsigned LW        = $clog2(BEATS * NumUnits + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                       r_state;
    logic [NumOperands*Width-1:0] r_ops;
    logic [NumOperands-1:0]       r_boxed;
    logic                         r_vec;
    logic [TagWidth-1:0]          r_tag;
    logic [BW-1:0]                r_iss_beat;
    logic [BW-1:0]                r_col_beat;
    logic [NumUnits-1:0]          r_iss_mask;
    logic [NumUnits-1:0]          r_col_mask;
    logic [Width-1:0]             r_result;
    logic [4:0]                   r_status;
    logic                         r_ext;

    logic [BW-1:0]       w_beats_eff;
    logic [LW-1:0]       w_iss_lane [NumUnits];
    logic [LW-1:0]       w_iss_sel  [NumUnits];
    logic [LW-1:0]       w_col_lane [NumUnits];
    logic [NumUnits-1:0] w_iss_act, w_col_act, w_iss_acc, w_issued, w_cap;
    logic [4:0]          w_cap_status;
    logic                w_iss_adv, w_col_adv, w_col_last;
    logic                w_unused_ext;

    assign w_beats_eff  = r_vec ? BW'(BEATS) : BW'(1);
    assign w_unused_ext = ^unit_ext_bit_i;

    // A unit is active in a beat when its lane exists; scalar ops only use lane 0.
    always_comb begin
        for (int u = 0; u < NumUnits; u++) begin
            w_iss_lane[u] = LW'(r_iss_beat) * LW'(NumUnits) + LW'(u);
            w_col_lane[u] = LW'(r_col_beat) * LW'(NumUnits) + LW'(u);
            w_iss_act[u]  = (r_state == S_RUN) && (r_iss_beat < w_beats_eff)
                            && (w_iss_lane[u] < LW'(NUM_LANES))
                            && (r_vec || (w_iss_lane[u] == '0));
            w_col_act[u]  = (r_state == S_RUN) && (r_col_beat < w_beats_eff)
                            && (w_col_lane[u] < LW'(NUM_LANES))
                            && (r_vec || (w_col_lane[u] == '0));
            w_iss_sel[u]  = w_iss_act[u] ? w_iss_lane[u] : '0;
        end
    end

    assign unit_valid_o = w_iss_act & ~r_iss_mask;
    assign w_iss_acc    = unit_valid_o & unit_ready_i;
    assign w_iss_adv    = (w_iss_act != '0) && ((w_iss_act & ~(r_iss_mask | w_iss_acc)) == '0);

    // Units return in order, so a unit may deliver once its beat has been issued to it.
    assign w_issued         = (r_col_beat < r_iss_beat) ? '1 : (r_iss_mask | w_iss_acc);
    assign unit_out_ready_o = w_col_act & ~r_col_mask & w_issued;
    assign w_cap            = unit_out_ready_o & unit_out_valid_i;
    assign w_col_adv        = (w_col_act != '0) && ((w_col_act & ~(r_col_mask | w_cap)) == '0);
    assign w_col_last       = w_col_adv && (r_col_beat == w_beats_eff - BW'(1));

    always_comb begin
        unit_operands_o = '0;
        unit_is_boxed_o = '0;
        w_cap_status    = '0;
        for (int u = 0; u < NumUnits; u++) begin
            for (int k = 0; k < NumOperands; k++) begin
                unit_operands_o[(u*NumOperands + k)*FpWidth +: FpWidth] =
                    r_ops[k*Width + int'(w_iss_sel[u])*FpWidth +: FpWidth];
            end
            unit_is_boxed_o[u*NumOperands +: NumOperands] = r_vec ? '1 : r_boxed;
            if (w_cap[u]) begin
                w_cap_status = w_cap_status | unit_status_i[u*5 +: 5];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_ops      <= '0;
            r_boxed    <= '0;
            r_vec      <= 1'b0;
            r_tag      <= '0;
            r_iss_beat <= '0;
            r_col_beat <= '0;
            r_iss_mask <= '0;
            r_col_mask <= '0;
            r_result   <= '0;
            r_status   <= '0;
            r_ext      <= 1'b0;
        end else if (flush_i) begin
            r_state    <= S_IDLE;
            r_iss_beat <= '0;
            r_col_beat <= '0;
            r_iss_mask <= '0;
            r_col_mask <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        r_ops      <= operands_i;
                        r_boxed    <= is_boxed_i;
                        r_vec      <= vectorial_op_i & EnableVectors;
                        r_tag      <= tag_i;
                        r_iss_beat <= '0;
                        r_col_beat <= '0;
                        r_iss_mask <= '0;
                        r_col_mask <= '0;
                        r_result   <= '0;
                        r_status   <= '0;
                        r_ext      <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_iss_adv) begin
                        r_iss_beat <= r_iss_beat + BW'(1);
                        r_iss_mask <= '0;
                    end else begin
                        r_iss_mask <= r_iss_mask | w_iss_acc;
                    end
                    if (w_col_adv) begin
                        r_col_beat <= r_col_beat + BW'(1);
                        r_col_mask <= '0;
                    end else begin
                        r_col_mask <= r_col_mask | w_cap;
                    end
                    for (int u = 0; u < NumUnits; u++) begin
                        if (w_cap[u]) begin
                            r_result[int'(w_col_lane[u])*FpWidth +: FpWidth] <=
                                unit_result_i[u*FpWidth +: FpWidth];
                        end
                    end
                    r_status <= r_status | w_cap_status;
                    if (w_cap[0] && (r_col_beat == '0)) begin
                        r_ext <= unit_ext_bit_i[0];
                    end
                    if (w_col_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        r_state    <= S_IDLE;
                        r_iss_beat <= '0;
                        r_col_beat <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Scalar results replicate the lane-0 extension bit (NaN-box or sign-extend).
    generate
        if (Width > FpWidth) begin : g_ext
            assign result_o = r_vec ? r_result
                                    : {{(Width-FpWidth){r_ext}}, r_result[FpWidth-1:0]};
        end else begin : g_noext
            assign result_o = r_result;
        end
    endgenerate

    assign in_ready_o      = (r_state == S_IDLE) && !flush_i;
    assign out_valid_o     = (r_state == S_DONE);
    assign busy_o          = (r_state != S_IDLE);
    assign status_o        = r_status;
    assign extension_bit_o = r_ext;
    assign tag_o           = r_tag;
    assign unit_flush_o    = flush_i;

`ifdef FPNEW_LANE_SEQ_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_RUN) && ((unit_valid_o & ~unit_ready_i) != '0)
                     && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpnew_lane_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for fpnew_lane_sequencer: unit models, scoreboard and a lane-level reference model.
module tb_fpnew_lane_sequencer;
    localparam int W = 64, FW = 16, NU = 2, NO = 3, TW = 8, NL = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NO*W-1:0]   operands_i;
    logic [NO-1:0]     is_boxed_i;
    logic              vectorial_op_i;
    logic [TW-1:0]     tag_i;
    logic              in_valid_i, in_ready_o, flush_i;
    logic [W-1:0]      result_o;
    logic [4:0]        status_o;
    logic              extension_bit_o;
    logic [TW-1:0]     tag_o;
    logic              out_valid_o, out_ready_i, busy_o;
    logic [NU*NO*FW-1:0] unit_operands_o;
    logic [NU*NO-1:0]  unit_is_boxed_o;
    logic [NU-1:0]     unit_valid_o, unit_ready_i;
    logic [NU*FW-1:0]  unit_result_i;
    logic [NU*5-1:0]   unit_status_i;
    logic [NU-1:0]     unit_ext_bit_i, unit_out_valid_i, unit_out_ready_o;
    logic              unit_flush_o;
    logic [31:0]       stall_cnt_o;

    fpnew_lane_sequencer #(
        .Width(W), .FpWidth(FW), .NumUnits(NU), .NumOperands(NO),
        .TagWidth(TW), .EnableVectors(1'b1)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .operands_i(operands_i), .is_boxed_i(is_boxed_i),
        .vectorial_op_i(vectorial_op_i), .tag_i(tag_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .flush_i(flush_i), .result_o(result_o),
        .status_o(status_o), .extension_bit_o(extension_bit_o), .tag_o(tag_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .busy_o(busy_o),
        .unit_operands_o(unit_operands_o), .unit_is_boxed_o(unit_is_boxed_o),
        .unit_valid_o(unit_valid_o), .unit_ready_i(unit_ready_i),
        .unit_result_i(unit_result_i), .unit_status_i(unit_status_i),
        .unit_ext_bit_i(unit_ext_bit_i), .unit_out_valid_i(unit_out_valid_i),
        .unit_out_ready_o(unit_out_ready_o), .unit_flush_o(unit_flush_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [W-1:0]  res;
        logic [4:0]    st;
        logic          ext;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    bit          rnd_mode = 1'b0;
    int          lat_max  = 1;
    int          force_nr [NU];
    int          out_hold = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Each lane computes a^b^{boxed,13'b0}, reports c[4:0] as status and c[15] as ext bit.
    function automatic exp_t ref_model(input logic [NO*W-1:0] ops, input logic [NO-1:0] bx,
                                       input logic vec, input logic [TW-1:0] tag);
        exp_t          e;
        logic [FW-1:0] lane_res [NL];
        logic [NO-1:0] be;
        logic [FW-1:0] a, b, c;
        int            nl;
        nl = vec ? NL : 1;
        be = vec ? '1 : bx;
        e  = '0;
        for (int l = 0; l < NL; l++) lane_res[l] = '0;
        for (int l = 0; l < nl; l++) begin
            a = ops[l*FW +: FW];
            b = ops[W + l*FW +: FW];
            c = ops[2*W + l*FW +: FW];
            lane_res[l] = a ^ b ^ {be, 13'h0};
            e.st = e.st | c[4:0];
            if (l == 0) e.ext = c[15];
        end
        if (vec) e.res = {lane_res[3], lane_res[2], lane_res[1], lane_res[0]};
        else     e.res = {{(W-FW){e.ext}}, lane_res[0]};
        e.tag = tag;
        return e;
    endfunction

    // Physical unit models: in-order FIFOs with per-item latency.
    logic [21:0] uq [NU][$];
    int unsigned ut [NU][$];
    initial begin : env
        logic [NU-1:0]       acc, cap;
        logic                fl;
        logic [NU*NO*FW-1:0] ops_s;
        logic [NU*NO-1:0]    bx_s;
        logic [FW-1:0]       a, b, c;
        logic [NO-1:0]       bx;
        for (int u = 0; u < NU; u++) force_nr[u] = 0;
        unit_ready_i = '1; unit_out_valid_i = '0; unit_result_i = '0;
        unit_status_i = '0; unit_ext_bit_i = '0; out_ready_i = 1'b1;
        forever begin
            @(negedge clk_i);
            acc   = unit_valid_o & unit_ready_i;
            cap   = unit_out_valid_i & unit_out_ready_o;
            fl    = unit_flush_o | rst_i;
            ops_s = unit_operands_o;
            bx_s  = unit_is_boxed_o;
            @(posedge clk_i);
            #1;
            cyc++;
            for (int u = 0; u < NU; u++) begin
                if (fl) begin
                    uq[u].delete();
                    ut[u].delete();
                end else begin
                    if (cap[u]) begin
                        void'(uq[u].pop_front());
                        void'(ut[u].pop_front());
                    end
                    if (acc[u]) begin
                        a  = ops_s[(u*NO + 0)*FW +: FW];
                        b  = ops_s[(u*NO + 1)*FW +: FW];
                        c  = ops_s[(u*NO + 2)*FW +: FW];
                        bx = bx_s[u*NO +: NO];
                        uq[u].push_back({c[15], c[4:0], a ^ b ^ {bx, 13'h0}});
                        ut[u].push_back(cyc + (rnd_mode ? $urandom_range(0, lat_max-1) : 0));
                    end
                end
                unit_out_valid_i[u] = 1'b0;
                unit_result_i[u*FW +: FW] = '0;
                unit_status_i[u*5 +: 5] = '0;
                unit_ext_bit_i[u] = 1'b0;
                if (uq[u].size() > 0) begin
                    unit_out_valid_i[u] = (ut[u][0] <= cyc);
                    unit_result_i[u*FW +: FW] = uq[u][0][15:0];
                    unit_status_i[u*5 +: 5] = uq[u][0][20:16];
                    unit_ext_bit_i[u] = uq[u][0][21];
                end
                if (force_nr[u] > 0 && busy_o) begin
                    unit_ready_i[u] = 1'b0;
                    force_nr[u]--;
                end else begin
                    unit_ready_i[u] = rnd_mode ? ($urandom_range(0, 9) < 7) : 1'b1;
                end
            end
            if (out_hold > 0 && out_valid_o) begin
                out_ready_i = 1'b0;
                out_hold--;
            end else begin
                out_ready_i = rnd_mode ? ($urandom_range(0, 9) < 6) : 1'b1;
            end
        end
    end

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_i || flush_i) begin
                if (busy_o) exp_q.delete();
            end else begin
                if (in_valid_i && in_ready_o)
                    exp_q.push_back(ref_model(operands_i, is_boxed_i, vectorial_op_i, tag_i));
                if (out_valid_o && out_ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 64'(out_valid_o), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_result", result_o, e.res);
                        check("out_status", 64'(status_o), 64'(e.st));
                        check("out_ext", 64'(extension_bit_o), 64'(e.ext));
                        check("out_tag", 64'(tag_o), 64'(e.tag));
                    end
                end
            end
        end
    end

    task automatic send(input logic [NO*W-1:0] ops, input logic [NO-1:0] bx,
                        input logic vec, input logic [TW-1:0] tag);
        bit ok;
        ok = 1'b0;
        operands_i = ops; is_boxed_i = bx; vectorial_op_i = vec; tag_i = tag;
        in_valid_i = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_i);
            ok = in_ready_o;
            @(posedge clk_i);
            #1;
        end
        in_valid_i = 1'b0;
        if (!ok) check("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk_i);
            ok = out_valid_o && out_ready_i;
            @(posedge clk_i);
            #1;
        end
        if (!ok) check("done_timeout", 64'd1, 64'd0);
    endtask

    task automatic check_reset(input string p);
        check({p, "_in_ready"}, 64'(in_ready_o), 64'd1);
        check({p, "_out_valid"}, 64'(out_valid_o), 64'd0);
        check({p, "_busy"}, 64'(busy_o), 64'd0);
        check({p, "_result"}, result_o, 64'd0);
        check({p, "_status"}, 64'(status_o), 64'd0);
        check({p, "_tag"}, 64'(tag_o), 64'd0);
        check({p, "_ext"}, 64'(extension_bit_o), 64'd0);
        check({p, "_unit_valid"}, 64'(unit_valid_o), 64'd0);
        check({p, "_unit_out_ready"}, 64'(unit_out_ready_o), 64'd0);
        check({p, "_stall_cnt"}, 64'(stall_cnt_o), 64'd0);
    endtask

    function automatic logic [NO*W-1:0] rnd_ops();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin : stim
        logic [NO*W-1:0] ops;
        logic [31:0]     st0;
        exp_t            e;
        int              n;
        bit              seen;
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; operands_i = '0;
        is_boxed_i = '0; vectorial_op_i = 1'b0; tag_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check_reset("reset");
        @(posedge clk_i); #1;

        // Scalar: lane0 = 3C00, ext bit 1, result NaN-boxed with ones.
        ops = '0;
        ops[15:0] = 16'h3C00;
        ops[2*W + 15] = 1'b1;
        send(ops, 3'b000, 1'b0, 8'hA5);
        @(negedge clk_i);
        check("scalar_issue", 64'(unit_valid_o), 64'd1);
        n = 1;
        while (!out_valid_o && n < 50) begin @(negedge clk_i); n++; end
        check("scalar_latency", 64'(n), 64'd3);
        check("scalar_result", result_o, 64'hFFFF_FFFF_FFFF_3C00);
        @(posedge clk_i); #1;

        // Vector: four lanes over two beats, status ORed.
        ops = {64'h0004_0000_0001_0000, 64'hE000_E000_E000_E000, 64'h4444_3333_2222_1111};
        send(ops, 3'b000, 1'b1, 8'h3C);
        @(negedge clk_i);
        check("vec_issue_beat0", 64'(unit_valid_o), 64'd3);
        n = 1;
        while (!out_valid_o && n < 50) begin @(negedge clk_i); n++; end
        check("vec_latency", 64'(n), 64'd4);
        check("vec_result", result_o, 64'h4444_3333_2222_1111);
        check("vec_status", 64'(status_o), 64'b00101);
        @(posedge clk_i); #1;

        // Backpressure on unit1 in beat0: unit0 must not be re-issued.
        st0 = stall_cnt_o;
        force_nr[1] = 3;
        send(rnd_ops(), 3'b101, 1'b1, 8'h77);
        @(negedge clk_i);
        check("bp_issue_c1", 64'(unit_valid_o), 64'd3);
        @(negedge clk_i);
        check("bp_issue_c2", 64'(unit_valid_o), 64'd2);
        @(posedge clk_i); #1;
        wait_done();
`ifdef FPNEW_LANE_SEQ_STALL_CNT_EN
        check("bp_stall_cnt", 64'(stall_cnt_o - st0), 64'd3);
`else
        check("bp_stall_cnt", 64'(stall_cnt_o), 64'd0);
`endif

        // Output backpressure: DONE holds for five cycles with stable outputs.
        ops = rnd_ops();
        e = ref_model(ops, 3'b011, 1'b0, 8'h5A);
        out_hold = 5;
        send(ops, 3'b011, 1'b0, 8'h5A);
        n = 0;
        while (!out_valid_o && n < 50) begin @(negedge clk_i); n++; end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk_i);
            check("hold_valid", 64'(out_valid_o), 64'd1);
            check("hold_ready", 64'(out_ready_i), 64'd0);
            check("hold_result", result_o, e.res);
            check("hold_tag", 64'(tag_o), 64'(e.tag));
            check("hold_in_ready", 64'(in_ready_o), 64'd0);
        end
        @(posedge clk_i); #1;
        wait_done();
        @(negedge clk_i);
        check("hold_idle", 64'(busy_o), 64'd0);
        @(posedge clk_i); #1;

        // Flush mid-RUN with a competing in_valid_i.
        send(rnd_ops(), 3'b000, 1'b1, 8'h11);
        @(posedge clk_i); #1;
        flush_i = 1'b1; in_valid_i = 1'b1; operands_i = rnd_ops(); tag_i = 8'h22;
        @(negedge clk_i);
        check("flush_in_ready", 64'(in_ready_o), 64'd0);
        check("flush_unit_flush", 64'(unit_flush_o), 64'd1);
        @(posedge clk_i); #1;
        flush_i = 1'b0; in_valid_i = 1'b0;
        @(negedge clk_i);
        check("flush_idle", 64'(busy_o), 64'd0);
        check("flush_unit_out_ready", 64'(unit_out_ready_o), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            seen = seen | out_valid_o;
        end
        check("flush_no_output", 64'(seen), 64'd0);
        @(posedge clk_i); #1;

        // Randomized traffic with random readiness and latency.
        rnd_mode = 1'b1;
        lat_max  = 3;
        for (int i = 0; i < 40; i++) begin
            send(rnd_ops(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)));
            wait_done();
        end
        rnd_mode = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of RUN drops the op.
        send(rnd_ops(), 3'b000, 1'b1, 8'h99);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_reset("midrun_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
